// File: rtl/ni_flit_transmitter.sv
// ni_flit_transmitter: packet-injection side of a router input port.
// Accepts one packet descriptor, then emits HEADER/BODY/TAIL flits, one per
// granted cycle, holding req to the arbiter for the whole packet.
// Optional feature macro: CREDIT_FLOW_EN (credit-based flow control with the
// credit_in port); the default build has no credit counter.
module ni_flit_transmitter #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned DEST_W  = 4,
    parameter int unsigned CREDITS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pkt_valid,
    output logic              pkt_ready,
    input  logic [DEST_W-1:0] pkt_dest,
    input  logic [11:0]       pkt_len,
    input  logic              pld_valid,
    output logic              pld_ready,
    input  logic [DATA_W-1:0] pld_data,
    output logic              req,
    input  logic              grant,
    output logic              flit_valid,
    output logic [2:0]        flit_type,
    output logic [11:0]       length,
    output logic [DATA_W-1:0] flit_data
`ifdef CREDIT_FLOW_EN
    ,
    input  logic              credit_in
`endif
);

    typedef enum logic [1:0] {IDLE, HEAD, BODY} state_t;

    localparam logic [2:0] T_HEADER = 3'b001;
    localparam logic [2:0] T_BODY   = 3'b010;
    localparam logic [2:0] T_TAIL   = 3'b100;

    state_t            state, state_nxt;
    logic [DEST_W-1:0] dest;
    logic [11:0]       remaining;
    logic [11:0]       len_c;
    logic [DATA_W-1:0] head_word;
    logic              credit_ok, ok, accept, send_head, send_body, sent, last;

`ifdef CREDIT_FLOW_EN
    localparam int unsigned    CW       = ($clog2(CREDITS + 1) > 4) ? $clog2(CREDITS + 1) : 4;
    localparam logic [CW-1:0]  CRED_MAX = CW'(CREDITS);

    logic [CW-1:0] credits;

    assign credit_ok = (credits != '0);

    // downstream credit counter: a send and a returned credit on the same edge cancel
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            credits <= CRED_MAX;
        end else if (sent && !credit_in) begin
            credits <= credits - 1'b1;
        end else if (!sent && credit_in && (credits != CRED_MAX)) begin
            credits <= credits + 1'b1;
        end
    end
`else
    assign credit_ok = 1'b1;
`endif

    assign ok     = grant & credit_ok;
    assign len_c  = (pkt_len < 12'd2) ? 12'd2 : pkt_len;
    assign accept = pkt_ready & pkt_valid;
    assign sent   = send_head | send_body;
    assign last   = (remaining == 12'd1);

    // header word: destination in the top bits, packet length in the low 12 bits
    always_comb begin
        head_word                      = '0;
        head_word[DATA_W-1 -: DEST_W]  = dest;
        head_word[11:0]                = length;
    end

    // next state and combinational handshakes
    always_comb begin
        state_nxt = state;
        pkt_ready = 1'b0;
        pld_ready = 1'b0;
        send_head = 1'b0;
        send_body = 1'b0;
        unique case (state)
            IDLE: begin
                pkt_ready = 1'b1;
                if (pkt_valid) state_nxt = HEAD;
            end
            HEAD: begin
                send_head = ok;
                if (ok) state_nxt = BODY;
            end
            BODY: begin
                pld_ready = ok;
                send_body = ok & pld_valid;
                if (send_body && last) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // packet context: latched descriptor, flits left after the header, request
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dest      <= '0;
            remaining <= '0;
            length    <= '0;
            req       <= 1'b0;
        end else if (accept) begin
            dest      <= pkt_dest;
            remaining <= len_c - 12'd1;
            length    <= len_c;
            req       <= 1'b1;
        end else if (send_body) begin
            remaining <= remaining - 12'd1;
            if (last) req <= 1'b0;
        end
    end

    // registered flit output, one-cycle pulse per flit sent
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flit_valid <= 1'b0;
            flit_type  <= 3'b000;
            flit_data  <= '0;
        end else begin
            flit_valid <= sent;
            flit_type  <= send_head ? T_HEADER :
                          send_body ? (last ? T_TAIL : T_BODY) : 3'b000;
            flit_data  <= send_head ? head_word :
                          send_body ? pld_data : '0;
        end
    end

endmodule

// File: tb/tb_ni_flit_transmitter.sv
// Self-checking bench for ni_flit_transmitter: a packet-level model (flit
// index within the packet, payload word count) predicts every cycle's
// outputs; directed scenarios pin literal flit contents and timing, then a
// randomized phase runs against the same model.
`timescale 1ns/1ps
module tb_ni_flit_transmitter;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned DEST_W   = 4;
    localparam int unsigned CREDITS  = 2;
    localparam logic [31:0] PLD_BASE = 32'hA500_0000;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              pkt_valid = 1'b0;
    logic              pkt_ready;
    logic [DEST_W-1:0] pkt_dest = '0;
    logic [11:0]       pkt_len = '0;
    logic              pld_valid = 1'b0;
    logic              pld_ready;
    logic [DATA_W-1:0] pld_data = PLD_BASE;
    logic              req;
    logic              grant = 1'b0;
    logic              flit_valid;
    logic [2:0]        flit_type;
    logic [11:0]       length;
    logic [DATA_W-1:0] flit_data;
`ifdef CREDIT_FLOW_EN
    logic              credit_in = 1'b1;
`endif

    always #5 clk = ~clk;

    ni_flit_transmitter #(
        .DATA_W (DATA_W),
        .DEST_W (DEST_W),
        .CREDITS(CREDITS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pkt_valid (pkt_valid),
        .pkt_ready (pkt_ready),
        .pkt_dest  (pkt_dest),
        .pkt_len   (pkt_len),
        .pld_valid (pld_valid),
        .pld_ready (pld_ready),
        .pld_data  (pld_data),
        .req       (req),
        .grant     (grant),
        .flit_valid(flit_valid),
        .flit_type (flit_type),
        .length    (length),
        .flit_data (flit_data)
`ifdef CREDIT_FLOW_EN
        ,
        .credit_in (credit_in)
`endif
    );

    int unsigned n_pass = 0;
    int unsigned n_checks = 0;
    int unsigned cyc_n = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc_n);
    endfunction

    function automatic void fail_bound(string name);
        n_checks++;
        $display("FAIL %s: got timeout required event (cycle %0d)", name, cyc_n);
    endfunction

    // ---------------- behavioural model ----------------
    bit          m_active = 1'b0;
    int unsigned m_len = 0;
    int unsigned m_sent = 0;
    int unsigned m_credits = CREDITS;
    logic [3:0]  m_dest = '0;
    int unsigned consumed_cnt = 0;
    int unsigned acc_cnt = 0;

    logic        e_req = 1'b0, e_valid = 1'b0;
    logic [2:0]  e_type = 3'b000;
    logic [11:0] e_length = '0;
    logic [31:0] e_data = '0;

    typedef struct {
        logic [2:0]  t;
        logic [31:0] d;
        int unsigned c;
        logic [11:0] len;
        logic        r;
    } obs_t;
    obs_t obs[$];

    // per-cycle compare and model step, mid-cycle while inputs are stable
    always @(negedge clk) begin : cmp
        logic m_ok, go, e_pkt_ready, e_pld_ready, cin;
        cyc_n++;
        if (!rst) begin
            m_active  = 1'b0;
            m_sent    = 0;
            m_len     = 0;
            m_credits = CREDITS;
            e_req = 1'b0; e_valid = 1'b0; e_type = 3'b000; e_length = '0; e_data = '0;
        end
        chk("req", 32'(req), 32'(e_req));
        chk("flit_valid", 32'(flit_valid), 32'(e_valid));
        chk("flit_type", 32'(flit_type), 32'(e_type));
        chk("length", 32'(length), 32'(e_length));
        if (e_valid || !rst) chk("flit_data", flit_data, e_data);
        if (flit_valid) obs.push_back('{flit_type, flit_data, cyc_n, length, req});

        m_ok        = grant && (m_credits != 0);
        e_pkt_ready = !rst || !m_active;
        e_pld_ready = rst && m_active && (m_sent > 0) && m_ok;
        chk("pkt_ready", 32'(pkt_ready), 32'(e_pkt_ready));
        chk("pld_ready", 32'(pld_ready), 32'(e_pld_ready));

        if (rst) begin
            e_valid = 1'b0; e_type = 3'b000; e_data = '0;
            go = 1'b0;
            if (!m_active) begin
                if (pkt_valid) begin
                    m_active = 1'b1;
                    m_len    = (pkt_len < 12'd2) ? 2 : int'(pkt_len);
                    m_dest   = pkt_dest;
                    m_sent   = 0;
                    e_length = 12'(m_len);
                    e_req    = 1'b1;
                    acc_cnt++;
                end
            end else if (m_ok && (m_sent == 0 || pld_valid)) begin
                go      = 1'b1;
                e_valid = 1'b1;
                if (m_sent == 0) begin
                    e_type = 3'b001;
                    e_data = (32'(m_dest) << (DATA_W - DEST_W)) | 32'(m_len);
                end else begin
                    e_type = (m_sent == m_len - 1) ? 3'b100 : 3'b010;
                    e_data = pld_data;
                    consumed_cnt++;
                end
                m_sent++;
                if (m_sent == m_len) begin
                    m_active = 1'b0;
                    e_req    = 1'b0;
                end
            end
`ifdef CREDIT_FLOW_EN
            cin = credit_in;
            if (go && !cin) m_credits--;
            else if (!go && cin && m_credits < CREDITS) m_credits++;
`else
            cin = 1'b0;
`endif
        end
    end

    // ---------------- stimulus ----------------
    bit rand_mode = 1'b0;

    task automatic cyc();
        @(posedge clk);
        #1;
        pld_data = rand_mode ? $urandom : PLD_BASE + consumed_cnt;
    endtask

    task automatic send_desc(input logic [3:0] d, input logic [11:0] l);
        int unsigned a0;
        a0 = acc_cnt;
        pkt_dest  = d;
        pkt_len   = l;
        pkt_valid = 1'b1;
        for (int i = 0; i < 50 && acc_cnt == a0; i++) cyc();
        pkt_valid = 1'b0;
        if (acc_cnt == a0) fail_bound("accept_wait");
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300 && m_active; i++) cyc();
        if (m_active) fail_bound("packet_wait");
        repeat (2) cyc();
    endtask

    task automatic wait_flits(input int b, input int n);
        for (int i = 0; i < 200 && obs.size() < b + n; i++) cyc();
        if (obs.size() < b + n) fail_bound("flit_wait");
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got timeout required $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : drive
        int b;
        int unsigned w0;
        logic [2:0] t4[4];
        t4 = '{3'b001, 3'b010, 3'b010, 3'b100};

        repeat (3) cyc();
        rst = 1'b1;
        cyc();
        chk("reset_length", 32'(length), 32'd0);
        chk("reset_pkt_ready", 32'(pkt_ready), 32'd1);

        // basic packet: len 4, dest 3, continuous grant and payload
        grant = 1'b1; pld_valid = 1'b1;
        b = obs.size(); w0 = consumed_cnt;
        send_desc(4'd3, 12'd4);
        wait_idle();
        chk("basic_nflits", 32'(obs.size() - b), 32'd4);
        if (obs.size() >= b + 4) begin
            chk("basic_hdr", obs[b].d, 32'h3000_0004);
            for (int i = 0; i < 4; i++) chk("basic_type", 32'(obs[b+i].t), 32'(t4[i]));
            chk("basic_body1", obs[b+1].d, PLD_BASE + w0);
            chk("basic_tail", obs[b+3].d, PLD_BASE + w0 + 2);
            chk("basic_consec", obs[b+3].c - obs[b].c, 32'd3);
            chk("basic_len", 32'(obs[b+3].len), 32'd4);
            chk("basic_req_hdr", 32'(obs[b].r), 32'd1);
            chk("basic_req_tail", 32'(obs[b+3].r), 32'd0);
        end

        // grant loss for 3 cycles after the 2nd flit of a 5-flit packet
        b = obs.size(); w0 = consumed_cnt;
        send_desc(4'd5, 12'd5);
        wait_flits(b, 2);
        grant = 1'b0;
        repeat (3) cyc();
        grant = 1'b1;
        wait_idle();
        chk("gloss_nflits", 32'(obs.size() - b), 32'd5);
        if (obs.size() >= b + 5) begin
            chk("gloss_hdr", obs[b].d, 32'h5000_0005);
            for (int i = 1; i < 5; i++) chk("gloss_payload", obs[b+i].d, PLD_BASE + w0 + i - 1);
            chk("gloss_tail", 32'(obs[b+4].t), 32'd4);
            chk("gloss_span", obs[b+4].c - obs[b].c, 32'd7);
        end

        // short length: 1 is coerced to 2
        b = obs.size(); w0 = consumed_cnt;
        send_desc(4'd9, 12'd1);
        wait_idle();
        chk("short_nflits", 32'(obs.size() - b), 32'd2);
        if (obs.size() >= b + 2) begin
            chk("short_hdr", obs[b].d, 32'h9000_0002);
            chk("short_t0", 32'(obs[b].t), 32'd1);
            chk("short_t1", 32'(obs[b+1].t), 32'd4);
            chk("short_len", 32'(obs[b+1].len), 32'd2);
        end
        chk("short_words", consumed_cnt - w0, 32'd1);

        // payload starvation for 2 cycles mid-packet
        b = obs.size(); w0 = consumed_cnt;
        send_desc(4'd2, 12'd6);
        wait_flits(b, 2);
        pld_valid = 1'b0;
        #1;
        chk("starve_pld_ready", 32'(pld_ready), 32'd1);
        chk("starve_req", 32'(req), 32'd1);
        repeat (2) cyc();
        pld_valid = 1'b1;
        wait_idle();
        chk("starve_nflits", 32'(obs.size() - b), 32'd6);
        if (obs.size() >= b + 6)
            for (int i = 1; i < 6; i++) chk("starve_payload", obs[b+i].d, PLD_BASE + w0 + i - 1);

`ifdef CREDIT_FLOW_EN
        // credits: 2 flits then stall; one credit -> one flit; coinciding credit keeps count
        credit_in = 1'b0;
        b = obs.size();
        send_desc(4'd1, 12'd6);
        repeat (8) cyc();
        chk("cred_stall", 32'(obs.size() - b), 32'd2);
        credit_in = 1'b1; cyc(); credit_in = 1'b0;
        repeat (5) cyc();
        chk("cred_one", 32'(obs.size() - b), 32'd3);
        credit_in = 1'b1; cyc(); cyc(); credit_in = 1'b0;
        repeat (5) cyc();
        chk("cred_coincide", 32'(obs.size() - b), 32'd5);
        credit_in = 1'b1; cyc(); credit_in = 1'b0;
        wait_idle();
        chk("cred_nflits", 32'(obs.size() - b), 32'd6);
        credit_in = 1'b1;
`endif

        // reset after the 2nd flit of a 6-flit packet
        b = obs.size();
        send_desc(4'd7, 12'd6);
        wait_flits(b, 2);
        rst = 1'b0;
        #2;
        chk("mrst_req", 32'(req), 32'd0);
        chk("mrst_valid", 32'(flit_valid), 32'd0);
        chk("mrst_type", 32'(flit_type), 32'd0);
        chk("mrst_length", 32'(length), 32'd0);
        chk("mrst_pkt_ready", 32'(pkt_ready), 32'd1);
        repeat (2) cyc();
        rst = 1'b1;
        cyc();
        b = obs.size(); w0 = consumed_cnt;
        send_desc(4'd4, 12'd3);
        wait_idle();
        chk("mrst_nflits", 32'(obs.size() - b), 32'd3);
        if (obs.size() >= b + 3) begin
            chk("mrst_hdr", obs[b].d, 32'h4000_0003);
            chk("mrst_t1", 32'(obs[b+1].t), 32'd2);
            chk("mrst_t2", 32'(obs[b+2].t), 32'd4);
            chk("mrst_body", obs[b+1].d, PLD_BASE + w0);
        end

        // randomized phase against the model
        rand_mode = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            pkt_valid = ($urandom % 4) == 0;
            pkt_dest  = 4'($urandom);
            pkt_len   = (($urandom % 16) == 0) ? 12'($urandom % 40) : 12'($urandom % 9);
            grant     = ($urandom % 4) != 0;
            pld_valid = ($urandom % 5) != 0;
`ifdef CREDIT_FLOW_EN
            credit_in = ($urandom % 2) == 0;
`endif
            rst = ($urandom % 600) != 0;
            cyc();
        end
        rst = 1'b1;
        pkt_valid = 1'b0;
        grant = 1'b1;
        pld_valid = 1'b1;
        repeat (3) cyc();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ni_flit_transmitter.md
# ni_flit_transmitter

- Packet-injection side of a router input port: takes one packet descriptor plus its payload words and segments them into HEADER/BODY/TAIL flits.
- Raises a request towards the output-port arbiter, holds it for the whole packet and emits one flit per granted cycle.
- Drives the flit type and packet length that the arbiter's per-port packet timer consumes, so the grant is held exactly for the packet length.
- Optional credit-based flow control towards the downstream input buffer.

## Interface
Parameters:
- DATA_W, 32, flit/payload width (≥ DEST_W+12)
- DEST_W, 4, destination field width
- CREDITS, 4, downstream buffer depth (credit counter reset value; CREDIT_FLOW_EN only)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- pkt_valid  in  1  descriptor valid
- pkt_ready  out  1  descriptor accepted when pkt_valid&pkt_ready
- pkt_dest  in  DEST_W  destination
- pkt_len  in  12  total flits in packet, header and tail included
- pld_valid  in  1  payload word valid
- pld_ready  out  1  payload word consumed when pld_valid&pld_ready
- pld_data  in  DATA_W  payload word
- req  out  1  request to arbiter
- grant  in  1  arbiter grant for this port (level)
- flit_valid  out  1  flit present
- flit_type  out  3  HEADER=3'b001, BODY=3'b010, TAIL=3'b100, 3'b000 when no flit
- length  out  12  latched packet length, stable for the whole packet
- flit_data  out  DATA_W  flit payload
- credit_in  in  1  one-cycle pulse returning one credit (CREDIT_FLOW_EN only)

## Operation
- States: IDLE, HEAD, BODY.
- IDLE:
  - pkt_ready=1; on accept, latch dest and length, set remaining=len-1, go to HEAD.
  - pkt_len of 0 or 1 is coerced to 2.
- Send condition: `ok = grant & credit_ok`. credit_ok=1 when CREDIT_FLOW_EN is not defined.
- HEAD:
  - On ok, emit HEADER with flit_data: [DATA_W-1 -: DEST_W]=dest, [11:0]=length, all other bits 0.
  - Then go to BODY.
- BODY:
  - pld_ready = ok (combinational); a flit is sent when ok & pld_valid. flit_data=pld_data.
  - Type is BODY while remaining>1, TAIL when remaining==1. remaining decrements per flit sent.
  - After TAIL go to IDLE.
- req:
  - Set on descriptor accept.
  - Cleared on the edge that sends TAIL.
  - Held through grant loss and payload starvation; a missing grant or payload word only stalls the packet, never truncates it.
- No new descriptor is accepted until the state is back in IDLE, so at most one packet is in flight.
- Reset (any time, including mid-packet): state=IDLE, remaining=0, credits=CREDITS.
  - Partial packet discarded; no TAIL is generated.

## Timing
- Reset values: req=0, flit_valid=0, flit_type=3'b000, length=0, flit_data=0, pkt_ready=1, pld_ready=0.
- Registered outputs: req, flit_valid, flit_type, length, flit_data. pkt_ready and pld_ready are combinational from state, grant and credits.
- Descriptor accepted at edge T → req=1 in cycle T+1.
- Grant first seen high in cycle G → HEADER visible cycle G+1.
- Each further flit is visible one cycle after the edge on which its send condition is true.
- Back-to-back flits with continuous grant and payload: len flits in len consecutive cycles.
- flit_valid is a one-cycle pulse per flit; flit_type=3'b000 whenever flit_valid=0.
- TAIL and req fall on the same edge.
- Next descriptor is accepted no earlier than the cycle after TAIL; its req rises the cycle after that.

## Configuration
- CREDIT_FLOW_EN defined:
  - 4-bit-min credit counter, reset to CREDITS. credit_ok = (credits != 0).
  - Decrement on each flit sent; increment on credit_in.
  - Simultaneous send and credit_in leaves it unchanged.
  - credit_in at credits==CREDITS with no send is ignored (saturate).
- CREDIT_FLOW_EN undefined: no counter, credit_in port absent, credit_ok=1.

## Test plan
- **Basic packet:** reset; pkt_len=4, dest=3, grant held 1, payload always valid → HEADER(data[DATA_W-1 -: 4]=3, [11:0]=4), BODY, BODY, TAIL on 4 consecutive cycles; req high from accept until the TAIL edge; length=4 throughout.
- **Grant loss:** pkt_len=5, grant dropped for 3 cycles after the 2nd flit → flit_valid=0 and req=1 during the gap; remaining 3 flits follow; TAIL last, with no dropped or duplicated payload words.
- **Short length:** pkt_len=1 → coerced; exactly HEADER then TAIL, length=2, one payload word consumed.
- **Credits (CREDIT_FLOW_EN, CREDITS=2):** pkt_len=6, no credit_in → 2 flits then stall; one credit_in pulse → exactly one more flit.
  - A send coinciding with credit_in keeps the count unchanged.
- **Reset mid-packet:** assert rst after the 2nd flit of a 6-flit packet → outputs take reset values immediately; after release, pkt_ready=1 and a new 3-flit packet is sent correctly.
- **Payload starvation:** pld_valid low for 2 cycles mid-packet with grant=1 → pld_ready=1 and flit_valid=0 during the gap; req stays 1.
